// File: rtl/spi_note_sender.sv
// SPI master (mode 0, no chip select) that serializes note commands into 48-bit packets.
// Optional command FIFO enabled by defining NOTE_SENDER_FIFO_EN; FIFO_DEPTH must be a power of two >= 2.
module spi_note_sender #(
  parameter int CLK_DIV    = 8,
  parameter int GAP_CYCLES = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_note_status,
  input  logic [7:0]  i_voice_index,
  input  logic [31:0] i_tuning_code,
  input  logic [6:0]  i_velocity,
  output logic        o_SPI_sclk,
  output logic        o_SPI_mosi,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, GAP} state_t;

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [5:0]  BIT_LAST = 6'd47;

  state_t      state_reg, state_next;
  logic [47:0] shift_reg, shift_next;
  logic [7:0]  div_reg, div_next;
  logic [5:0]  bit_reg, bit_next;
  logic [15:0] gap_reg, gap_next;

  logic [47:0] packet_in;
  logic [47:0] cmd_data;
  logic        cmd_avail;

  assign packet_in = {i_note_status, i_velocity, i_voice_index, i_tuning_code};

`ifdef NOTE_SENDER_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [47:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          push, pop, fifo_empty;

  assign fifo_empty = (count_reg == '0);
  assign o_ready    = (count_reg != (AW+1)'(FIFO_DEPTH));
  assign push       = i_valid && o_ready;
  // The serializer drains the FIFO from its IDLE cycle, so only one idle cycle separates packets.
  assign pop        = (state_reg == IDLE) && !fifo_empty;
  assign cmd_avail  = !fifo_empty;
  assign cmd_data   = fifo_mem[rd_ptr_reg];
  assign o_busy     = (state_reg != IDLE) || !fifo_empty;

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= packet_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
`else
  assign o_ready   = (state_reg == IDLE);
  assign cmd_avail = i_valid;
  assign cmd_data  = packet_in;
  assign o_busy    = (state_reg != IDLE);
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      div_reg   <= '0;
      bit_reg   <= '0;
      gap_reg   <= '0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      div_reg   <= div_next;
      bit_reg   <= bit_next;
      gap_reg   <= gap_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    div_next   = div_reg;
    bit_next   = bit_reg;
    gap_next   = gap_reg;
    case (state_reg)
      IDLE: begin
        div_next = '0;
        bit_next = '0;
        gap_next = '0;
        if (cmd_avail) begin
          shift_next = cmd_data;
          state_next = LOW;
        end
      end
      LOW: begin
        if (div_reg == DIV_LAST) begin
          div_next   = '0;
          state_next = HIGH;
        end else begin
          div_next = div_reg + 8'd1;
        end
      end
      HIGH: begin
        if (div_reg == DIV_LAST) begin
          div_next   = '0;
          // Shifting at the end of HIGH keeps mosi stable for the whole high phase.
          shift_next = {shift_reg[46:0], 1'b0};
          if (bit_reg == BIT_LAST) begin
            bit_next   = '0;
            state_next = GAP;
          end else begin
            bit_next   = bit_reg + 6'd1;
            state_next = LOW;
          end
        end else begin
          div_next = div_reg + 8'd1;
        end
      end
      GAP: begin
        if (gap_reg == GAP_LAST) begin
          gap_next   = '0;
          state_next = IDLE;
        end else begin
          gap_next = gap_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_SPI_sclk = (state_reg == HIGH);
  assign o_SPI_mosi = ((state_reg == LOW) || (state_reg == HIGH)) && shift_reg[47];
  assign o_done     = (state_reg == GAP) && (gap_reg == GAP_LAST);

endmodule

// File: tb/tb_spi_note_sender.sv
// Scoreboard bench for spi_note_sender: instance 0 runs CLK_DIV=2, instance 1 runs CLK_DIV=1, both GAP=4.
module tb_spi_note_sender;

  localparam int GAP = 4;
`ifdef NOTE_SENDER_FIFO_EN
  localparam int FIFO_LAT = 1;
`else
  localparam int FIFO_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  valid = '0;
  logic        note_status = 1'b0;
  logic [7:0]  voice = '0;
  logic [31:0] tuning = '0;
  logic [6:0]  vel = '0;
  logic [1:0]  ready_v, sclk_v, mosi_v, busy_v, done_v;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int hs_cyc = 0;
  logic [47:0] exp_q[$];
  logic [47:0] dropped;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      spi_note_sender #(
        .CLK_DIV   ((gi == 0) ? 2 : 1),
        .GAP_CYCLES(GAP),
        .FIFO_DEPTH(4)
      ) u_dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_valid      (valid[gi]),
        .o_ready      (ready_v[gi]),
        .i_note_status(note_status),
        .i_voice_index(voice),
        .i_tuning_code(tuning),
        .i_velocity   (vel),
        .o_SPI_sclk   (sclk_v[gi]),
        .o_SPI_mosi   (mosi_v[gi]),
        .o_busy       (busy_v[gi]),
        .o_done       (done_v[gi])
      );
    end
  endgenerate

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Decodes each instance's sclk/mosi stream and compares finished packets against the queue.
  task automatic monitor();
    int          bits[2];
    logic [47:0] acc[2];
    logic        ps[2], pm[2];
    bit          in_gap[2];
    int          gap_start[2], last_rise[2];
    logic [47:0] e;
    for (int k = 0; k < 2; k++) begin
      bits[k] = 0; acc[k] = '0; ps[k] = 1'b0; pm[k] = 1'b0;
      in_gap[k] = 1'b0; gap_start[k] = 0; last_rise[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          bits[k] = 0;
          in_gap[k] = 1'b0;
        end else begin
          if (sclk_v[k] && !ps[k]) begin
            chk("mosi_setup", mosi_v[k], pm[k]);
            if (bits[k] > 0) chk("sclk_period", cyc - last_rise[k], 2 * ((k == 0) ? 2 : 1));
            last_rise[k] = cyc;
            acc[k] = {acc[k][46:0], mosi_v[k]};
            bits[k]++;
            if (bits[k] == 48) begin
              if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_packet: got %012h expected none inst %0d", acc[k], k);
              end else begin
                e = exp_q.pop_front();
                chk("packet", acc[k], e);
                $display("inst %0d packet %012h at cycle %0d", k, acc[k], cyc);
              end
            end
          end else if (sclk_v[k] && ps[k]) begin
            chk("mosi_hold", mosi_v[k], pm[k]);
          end
          if (bits[k] == 48 && !sclk_v[k] && ps[k]) begin
            in_gap[k] = 1'b1;
            gap_start[k] = cyc;
          end
          if (in_gap[k]) chk("gap_lines_low", {sclk_v[k], mosi_v[k]}, 0);
          if (done_v[k]) begin
            chk("gap_len", in_gap[k] ? (cyc - gap_start[k] + 1) : 0, GAP);
            bits[k] = 0;
            in_gap[k] = 1'b0;
          end
        end
        ps[k] = sclk_v[k];
        pm[k] = mosi_v[k];
      end
    end
  endtask

  task automatic send(input int k, input logic on, input logic [7:0] vi, input logic [31:0] tc,
                      input logic [6:0] ve, input logic [47:0] expv);
    int n;
    exp_q.push_back(expv);
    note_status = on; voice = vi; tuning = tc; vel = ve;
    n = 0;
    @(negedge clk);
    while (!ready_v[k] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", ready_v[k], 1);
    valid[k] = 1'b1;
    hs_cyc = cyc + 1;
    @(negedge clk);
    valid[k] = 1'b0;
    chk("busy_after_hs", busy_v[k], 1);
  endtask

  task automatic wait_done(input int k, input int cd, input bit lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_v[k] && n < 5000);
    chk("done_seen", done_v[k], 1);
    if (lat) chk("done_latency", cyc - hs_cyc, 96 * cd + GAP - 1 + FIFO_LAT);
  endtask

  initial begin
    int   r, n;
    logic p;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_sclk", sclk_v[k], 0);
      chk("rst_mosi", mosi_v[k], 0);
      chk("rst_busy", busy_v[k], 0);
      chk("rst_done", done_v[k], 0);
      chk("rst_ready", ready_v[k], 1);
    end
    rst = 1'b0;

    // 1: note on, E4 03 12 34 56 78
    send(0, 1'b1, 8'h03, 32'h12345678, 7'd100, 48'hE4_03_12345678);
    wait_done(0, 2, 1'b1);

    // 2: all-zero payload except voice 0xFF
    send(0, 1'b0, 8'hFF, 32'h0, 7'd0, 48'h00_FF_00000000);
    wait_done(0, 2, 1'b1);
    @(negedge clk);
    chk("idle_busy", busy_v[0], 0);
    chk("idle_ready", ready_v[0], 1);

`ifndef NOTE_SENDER_FIFO_EN
    // 3: valid held high across two commands
    exp_q.push_back(48'h81_21_00000100);
    exp_q.push_back(48'h7F_7E_80000001);
    note_status = 1'b1; voice = 8'h21; tuning = 32'h00000100; vel = 7'h01;
    @(negedge clk);
    chk("t3_ready_a", ready_v[0], 1);
    valid[0] = 1'b1;
    @(negedge clk);
    note_status = 1'b0; voice = 8'h7E; tuning = 32'h80000001; vel = 7'h7F;
    chk("t3_ready_low", ready_v[0], 0);
    wait_done(0, 2, 1'b0);
    @(negedge clk);
    chk("t3_ready_after_done", ready_v[0], 1);
    chk("t3_busy_idle", busy_v[0], 0);
    @(negedge clk);
    hs_cyc = cyc;
    valid[0] = 1'b0;
    chk("t3_busy_b", busy_v[0], 1);
    chk("t3_ready_b", ready_v[0], 0);
    wait_done(0, 2, 1'b1);
`endif

    // 4: reset during bit 20, then a clean packet
    send(0, 1'b1, 8'h10, 32'hCAFEF00D, 7'h55, 48'hD5_10_CAFEF00D);
    r = 0; n = 0; p = sclk_v[0];
    while (r < 20 && n < 5000) begin
      @(negedge clk);
      n++;
      if (sclk_v[0] && !p) r++;
      p = sclk_v[0];
    end
    chk("bit20_reached", r, 20);
    rst = 1'b1;
    dropped = exp_q.pop_back();
    @(negedge clk);
    chk("abort_sclk", sclk_v[0], 0);
    chk("abort_mosi", mosi_v[0], 0);
    chk("abort_busy", busy_v[0], 0);
    chk("abort_ready", ready_v[0], 1);
    chk("abort_done", done_v[0], 0);
    @(negedge clk);
    rst = 1'b0;
    send(0, 1'b0, 8'h42, 32'h0F0F0F0F, 7'h01, 48'h01_42_0F0F0F0F);
    wait_done(0, 2, 1'b1);

`ifdef NOTE_SENDER_FIFO_EN
    // 5: five commands pushed back to back into the FIFO
    @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back({1'b1, 7'(i), 8'(i), 32'h10000000 + 32'(i)});
      note_status = 1'b1; vel = 7'(i); voice = 8'(i); tuning = 32'h10000000 + 32'(i);
      valid[0] = 1'b1;
      n = 0;
      while (!ready_v[0] && n < 5000) begin
        @(negedge clk);
        n++;
      end
      chk("fifo_ready", ready_v[0], 1);
      @(negedge clk);
    end
    valid[0] = 1'b0;
    chk("fifo_busy", busy_v[0], 1);
    for (int i = 0; i < 5; i++) wait_done(0, 2, 1'b0);
`endif

    // 6: CLK_DIV=1 instance
    send(1, 1'b1, 8'hA5, 32'hDEADBEEF, 7'h7F, 48'hFF_A5_DEADBEEF);
    wait_done(1, 1, 1'b1);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
